// File: rtl/mc_pkg.sv
// Shared widths, depths and FSM state encoding for the Monte-Carlo path feeder.
package mc_pkg;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned DATA_LENGTH = 256;
  localparam int unsigned DAY         = 8;
  localparam int unsigned ADDR_W      = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mc_path_ram.sv
// Path sample memory: one write port, one synchronous read port with read-first
// behaviour on a same-address collision. Read register resets; the array does not.
module mc_path_ram #(
  parameter int unsigned DATA_W = mc_pkg::DATA_W,
  parameter int unsigned DEPTH  = mc_pkg::DATA_LENGTH * mc_pkg::DAY,
  parameter int unsigned ADDR_W = mc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Disabled reads keep the last sample visible on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mc_path_feeder.sv
// Streams one day of path samples per pass to MC_CORE, replaying or advancing on resend.
// Define MC_FEEDER_LOOP_EN to wrap from the last day back to day 0 instead of finishing.
module mc_path_feeder #(
  parameter int unsigned DATA_W      = mc_pkg::DATA_W,
  parameter int unsigned DATA_LENGTH = mc_pkg::DATA_LENGTH,
  parameter int unsigned DAY         = mc_pkg::DAY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               go,
  input  logic [DATA_W-1:0]                  strike_in,
  input  logic                               wr_en,
  input  logic [$clog2(DATA_LENGTH*DAY)-1:0] wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic                               resend,
  output logic                               start,
  output logic [DATA_W-1:0]                  path,
  output logic [DATA_W-1:0]                  K,
  output logic [$clog2(DAY)-1:0]             day_idx,
  output logic                               pass,
  output logic                               busy,
  output logic                               done
);

  import mc_pkg::*;

  localparam int unsigned AW = $clog2(DATA_LENGTH * DAY);
  localparam int unsigned DW = $clog2(DAY);
  localparam int unsigned NW = $clog2(DATA_LENGTH);
  localparam logic [DW-1:0] LAST_DAY = DW'(DAY - 1);
  localparam logic [NW-1:0] LAST_N   = NW'(DATA_LENGTH - 1);

  state_t        state;
  logic [NW-1:0] n;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  function automatic logic [AW-1:0] sample_addr(input logic [DW-1:0] d, input logic [NW-1:0] i);
    return AW'(d) * AW'(DATA_LENGTH) + AW'(i);
  endfunction

  // Read address mirrors the next-state decision so the sample lands with the state.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = sample_addr(day_idx, n + 1'b1);
    case (state)
      IDLE, DONE: begin
        if (go) begin
          rd_en   = 1'b1;
          rd_addr = sample_addr('0, '0);
        end
      end
      START: begin
        rd_en   = 1'b1;
        rd_addr = sample_addr(day_idx, '0);
      end
      STREAM, WAIT: begin
        if (resend) begin
          if (!pass) begin
            rd_en   = 1'b1;
            rd_addr = sample_addr(day_idx, '0);
          end else if (day_idx != LAST_DAY) begin
            rd_en   = 1'b1;
            rd_addr = sample_addr(day_idx + 1'b1, '0);
          end
`ifdef MC_FEEDER_LOOP_EN
          else begin
            rd_en   = 1'b1;
            rd_addr = sample_addr('0, '0);
          end
`endif
        end else if (state == STREAM && n != LAST_N) begin
          rd_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      start   <= 1'b0;
      K       <= '0;
      day_idx <= '0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state   <= START;
            day_idx <= '0;
            pass    <= 1'b0;
            K       <= strike_in;
            start   <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        START: begin
          state <= STREAM;
          n     <= '0;
        end
        STREAM, WAIT: begin
          if (resend) begin
            if (!pass) begin
              pass  <= 1'b1;
              state <= START;
              start <= 1'b1;
            end else begin
              pass <= 1'b0;
              if (day_idx == LAST_DAY) begin
                day_idx <= '0;
`ifdef MC_FEEDER_LOOP_EN
                state   <= START;
                start   <= 1'b1;
`else
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
`endif
              end else begin
                day_idx <= day_idx + 1'b1;
                state   <= START;
                start   <= 1'b1;
              end
            end
          end else if (state == STREAM) begin
            if (n == LAST_N) state <= WAIT;
            else             n     <= n + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mc_path_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DATA_LENGTH * DAY),
    .ADDR_W(AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(path)
  );

endmodule

// File: tb/tb_mc_path_feeder.sv
// Directed bench for mc_path_feeder: control-step table plus hand-written abort, reset
// and write-collision sequences. Honours MC_FEEDER_LOOP_EN when defined.
module tb_mc_path_feeder;

  logic        clk = 1'b0;
  logic        rst, go, resend, wr_en;
  logic [11:0] strike_in, wr_data;
  logic [10:0] wr_addr;
  logic        start, pass, busy, done;
  logic [11:0] path, K;
  logic [2:0]  day_idx;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mc_path_feeder #(
    .DATA_W     (12),
    .DATA_LENGTH(256),
    .DAY        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .strike_in(strike_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .resend   (resend),
    .start    (start),
    .path     (path),
    .K        (K),
    .day_idx  (day_idx),
    .pass     (pass),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        go;
    logic        resend;
    logic [11:0] strike;
    int unsigned settle;
    logic        stream;
    logic        e_start;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic [2:0]  e_day;
    logic [11:0] e_path;
    logic [11:0] e_k;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic b, input logic d,
                         input logic p, input logic [2:0] dy, input logic [11:0] pa,
                         input logic [11:0] k);
    chk({tag, ".start"},   32'(start),   32'(s));
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".done"},    32'(done),    32'(d));
    chk({tag, ".pass"},    32'(pass),    32'(p));
    chk({tag, ".day_idx"}, 32'(day_idx), 32'(dy));
    chk({tag, ".path"},    32'(path),    32'(pa));
    chk({tag, ".K"},       32'(K),       32'(k));
  endtask

  task automatic add(input string nm, input logic g, input logic r, input logic [11:0] st,
                     input int unsigned settle, input logic strm, input logic es, input logic eb,
                     input logic ed, input logic ep, input logic [2:0] edy,
                     input logic [11:0] epa, input logic [11:0] ek);
    vec_t v;
    v.name = nm; v.go = g; v.resend = r; v.strike = st; v.settle = settle; v.stream = strm;
    v.e_start = es; v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_day = edy;
    v.e_path = epa; v.e_k = ek;
    vecs.push_back(v);
  endtask

  // Called one cycle after START: walks all 256 samples, then the WAIT hold.
  task automatic check_stream(input string tag, input logic [11:0] base);
    for (int unsigned i = 0; i < 256; i++) begin
      tick();
      chk({tag, ".stream_path"}, 32'(path), 32'(base + 12'(i)));
      if (i == 0) chk({tag, ".stream_start"}, 32'(start), 32'd0);
    end
    tick();
    chk({tag, ".wait_path"},  32'(path),  32'(base + 12'h0FF));
    chk({tag, ".wait_busy"},  32'(busy),  32'd1);
    chk({tag, ".wait_start"}, 32'(start), 32'd0);
  endtask

  initial begin
    logic [2:0] d;
    logic       p;

    rst = 1'b1; go = 1'b0; resend = 1'b0; wr_en = 1'b0;
    strike_in = '0; wr_data = '0; wr_addr = '0;

    add("go_start", 1'b1, 1'b0, 12'h300, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 12'h300);
    add("replay",   1'b0, 1'b1, 12'h000, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 12'h000, 12'h300);
    add("advance",  1'b0, 1'b1, 12'h000, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 12'h100, 12'h300);
    d = 3'd1;
    p = 1'b0;
    for (int unsigned r = 3; r <= 15; r++) begin
      if (!p) p = 1'b1;
      else begin d = d + 3'd1; p = 1'b0; end
      add($sformatf("resend%0d", r), 1'b0, 1'b1, 12'h000, 1, 1'b0,
          1'b0, 1'b1, 1'b0, p, d, {1'b0, d, 8'h00}, 12'h300);
    end
`ifdef MC_FEEDER_LOOP_EN
    add("loop_wrap",       1'b0, 1'b1, 12'h000, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 12'h300);
    add("resend_in_start", 1'b0, 1'b1, 12'h000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 12'h002, 12'h300);
`else
    add("run_done",        1'b0, 1'b1, 12'h000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 12'h700, 12'h300);
    add("resend_in_done",  1'b0, 1'b1, 12'h000, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 12'h700, 12'h300);
`endif

    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000);
    tick();
    rst = 1'b0;

    for (int unsigned i = 0; i < 2048; i++) begin
      wr_en = 1'b1; wr_addr = 11'(i); wr_data = 12'(i);
      tick();
    end
    wr_en = 1'b0;
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000);

    foreach (vecs[i]) begin
      go = vecs[i].go; resend = vecs[i].resend; strike_in = vecs[i].strike;
      tick();
      go = 1'b0; resend = 1'b0;
      repeat (vecs[i].settle) tick();
      chk_all(vecs[i].name, vecs[i].e_start, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_pass,
              vecs[i].e_day, vecs[i].e_path, vecs[i].e_k);
      if (vecs[i].stream) check_stream(vecs[i].name, vecs[i].e_path);
    end

    // Abort mid-stream: resend at n=10 of day 0 pass 0.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    go = 1'b1; strike_in = 12'h055;
    tick();
    go = 1'b0;
    chk_all("abort_go", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 12'h055);
    tick();
    repeat (10) tick();
    chk("abort_n10.path", 32'(path), 32'h00A);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    chk_all("abort_restart", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 12'h000, 12'h055);
    tick();
    chk("abort_n0.path", 32'(path), 32'h000);

    // Walk to day 3 pass 0, then reset at n=100.
    repeat (5) begin
      resend = 1'b1; tick(); resend = 1'b0; tick();
    end
    chk_all("day3_n0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 12'h300, 12'h055);
    repeat (100) tick();
    chk("day3_n100.path", 32'(path), 32'h364);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 12'h000);
    go = 1'b1; strike_in = 12'h0AA;
    tick();
    go = 1'b0;
    chk_all("restart_go", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 12'h0AA);
    tick();
    chk("restart_n0.path", 32'(path), 32'h000);

    // Same-cycle write/read of address 5 returns old data; go while busy is ignored.
    repeat (4) tick();
    chk("coll_n4.path", 32'(path), 32'h004);
    wr_en = 1'b1; wr_addr = 11'd5; wr_data = 12'hABC;
    tick();
    wr_en = 1'b0;
    chk("coll_n5.path", 32'(path), 32'h005);
    go = 1'b1; strike_in = 12'h111;
    tick();
    go = 1'b0;
    chk_all("go_ignored", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 12'h006, 12'h0AA);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    chk_all("replay_after_write", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 12'h000, 12'h0AA);
    tick();
    repeat (5) tick();
    chk("written_n5.path", 32'(path), 32'hABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_path_feeder.md
MC_PATH_FEEDER -- requirements
Module: mc_path_feeder

Interface
REQ-001 Parameter DATA_W, 12, width of one path sample and of the strike.
REQ-002 Parameter DATA_LENGTH, 256, samples per day.
REQ-003 Parameter DAY, 8, days stored; memory depth is DATA_LENGTH*DAY = 2048.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port go  in  1  one-cycle request to begin a run at day 0.
REQ-007 Port strike_in  in  DATA_W  strike; captured on an accepted go.
REQ-008 Port wr_en / wr_addr / wr_data  in  1 / 11 / DATA_W  path-memory load port.
REQ-009 Port resend  in  1  request from MC_CORE: replay the current day, or advance to the next day.
REQ-010 Port start  out  1  one-cycle pulse to MC_CORE at the beginning of each pass.
REQ-011 Port path  out  DATA_W  current path sample to MC_CORE.
REQ-012 Port K  out  DATA_W  registered strike to MC_CORE.
REQ-013 Port day_idx / pass / busy / done  out  3 / 1 / 1 / 1  status outputs: current day, pass (0 first, 1 replay), run active, run finished.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, START, STREAM, WAIT, DONE.
REQ-015 IDLE: go moves the FSM to START, sets day=0 and pass=0, and latches strike_in into K; go is ignored in every other state.
REQ-016 START: start=1 for exactly one cycle and path=mem[day*DATA_LENGTH]; the next state is STREAM with n=0.
REQ-017 STREAM: in cycle n, path SHALL equal mem[day*DATA_LENGTH+n], n=0..DATA_LENGTH-1, one sample per cycle with no bubbles.
REQ-018 After n=DATA_LENGTH-1 the FSM SHALL enter WAIT, and path SHALL hold the last sample.
REQ-019 When resend=1 in STREAM or WAIT and pass=0: set pass=1, keep day, go to START (the stream is aborted if it is still running).
REQ-020 When resend=1 in STREAM or WAIT and pass=1: day increments and pass=0; if the new day equals DAY the FSM goes to DONE, otherwise it goes to START.
REQ-021 resend SHALL be ignored in IDLE, START and DONE.
REQ-022 DONE: done=1, busy=0, path holds; go returns the FSM to IDLE-equivalent behaviour and starts a new run the same as REQ-015.
REQ-023 busy SHALL be 1 in START, STREAM and WAIT, and 0 otherwise.
REQ-024 Memory reads SHALL be synchronous with a 1-cycle latency; the read address SHALL be issued one cycle early so that REQ-016 and REQ-017 hold exactly.
REQ-025 A write to an address in the same cycle as a read of that address SHALL return the old data.
REQ-026 Writes SHALL be accepted in any state.
REQ-027 The day and n counters SHALL use unsigned compare; there is no wrap inside a day.

Reset
REQ-028 While rst=1 the block SHALL reset asynchronously to: state=IDLE, start=0, path=0, K=0, day_idx=0, pass=0, busy=0, done=0.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset asserted mid-stream SHALL abort the run; after release the block waits in IDLE for go.

Configuration
REQ-031 Macro MC_FEEDER_LOOP_EN: when defined, the day increment past DAY-1 wraps to day 0 and the FSM goes to START instead of DONE, so done stays 0.
REQ-032 When MC_FEEDER_LOOP_EN is undefined, the behaviour is exactly REQ-020 and REQ-022.

Structure
REQ-033 Package mc_pkg SHALL hold DATA_W, DATA_LENGTH, DAY, the address width (11), and the FSM state enum.
REQ-034 Sub-module mc_path_ram SHALL be used: 2048x12, one write port and one synchronous read port.

Verification
REQ-035 Test 1 (basic pass): load mem[i]=i; go with strike_in=0x300 -> K=0x300, start pulses once, then path=0x000..0x0FF on consecutive cycles, then WAIT holding 0x0FF.
REQ-036 Test 2 (replay then advance): in WAIT, resend -> pass=1 and 0x000..0x0FF repeats; second resend -> day_idx=1, start pulses, path=0x100..0x1FF.
REQ-037 Test 3 (abort mid-stream): resend at n=10 of day 0 pass 0 -> the next cycle is START with path=0x000 and pass=1.
REQ-038 Test 4 (run completion): complete 16 resends across 8 days -> done=1, busy=0, day_idx=0 (wrapped count value), and further resend has no effect; with MC_FEEDER_LOOP_EN defined -> START of day 0 and done stays 0.
REQ-039 Test 5 (reset mid-stream): assert rst at day 3 n=100 -> all outputs go to 0 immediately; go -> day 0 restarts at 0x000.
REQ-040 Test 6 (write collision and ignored go): write mem[5]=0xABC while streaming index 5 -> path at n=5 shows the old value; go while busy is ignored.
